// File: rtl/if_prefetch_queue.sv
// Instruction-fetch request generator feeding a DEPTH-entry {pc, instruction} prefetch FIFO.
// Optional macro IF_PREFETCH_BYPASS_EN forwards an arriving response to the outputs when the FIFO is empty.
module if_prefetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              PC_STEP  = 1,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int              PW        = $clog2(DEPTH);
  localparam int              CW        = $clog2(DEPTH + 1);
  localparam logic [CW:0]     DEPTH_OCC = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0]   LAST_PTR  = PW'(DEPTH - 1);

  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] req_pc_r;
  logic            inflight_r;
  logic [XLEN-1:0] pc_mem_r   [DEPTH];
  logic [XLEN-1:0] data_mem_r [DEPTH];
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;

  logic            empty_s;
  logic            bypass_s;
  logic            pop_s;
  logic            fifo_pop_s;
  logic            push_s;
  logic [CW:0]     occ_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    ptr_next = (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign empty_s   = (count_r == {CW{1'b0}});
  assign imem_addr = fetch_pc_r;

  // Head selection, handshake and issue decision; redirect and reset mask everything
  always_comb begin
    bypass_s   = 1'b0;
    inst_valid = 1'b0;
    inst_data  = data_mem_r[rd_ptr_r];
    inst_pc    = pc_mem_r[rd_ptr_r];
    if (rst_n && !redirect_valid) begin
      inst_valid = !empty_s;
`ifdef IF_PREFETCH_BYPASS_EN
      if (empty_s && inflight_r) begin
        bypass_s   = 1'b1;
        inst_valid = 1'b1;
        inst_data  = imem_rdata;
        inst_pc    = req_pc_r;
      end else begin
        bypass_s   = 1'b0;
      end
`endif
    end else begin
      inst_valid = 1'b0;
    end
    pop_s      = inst_valid && inst_ready;
    fifo_pop_s = pop_s && !bypass_s;
    push_s     = rst_n && !redirect_valid && inflight_r && !(bypass_s && pop_s);
    // occupancy counts the in-flight request so a full FIFO never receives an unmatched push
    occ_s      = {1'b0, count_r} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, pop_s};
    imem_req   = rst_n && !redirect_valid && (occ_s < DEPTH_OCC);
  end

  // Fetch PC, in-flight tracking, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      req_pc_r   <= RESET_PC;
      inflight_r <= 1'b0;
      count_r    <= {CW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
    end else if (redirect_valid) begin
      fetch_pc_r <= redirect_pc;
      inflight_r <= 1'b0;
      count_r    <= {CW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
    end else begin
      inflight_r <= imem_req;
      if (imem_req) begin
        fetch_pc_r <= fetch_pc_r + XLEN'(PC_STEP);
        req_pc_r   <= fetch_pc_r;
      end
      if (push_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (fifo_pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_s, fifo_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are only observed through count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]   <= req_pc_r;
      data_mem_r[wr_ptr_r] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized scoreboard bench for if_prefetch_queue against a queue-based reference model.
module tb_if_prefetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
`ifdef IF_PREFETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata = 32'h0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = 32'h0;
  logic            inst_valid;
  logic            inst_ready = 1'b0;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  if_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .PC_STEP(1), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } inst_t;
  typedef struct { bit rn; bit req; logic [31:0] addr; bit valid; } ctl_t;

  inst_t       mq[$];     // instructions the model holds as visible queue entries
  inst_t       sb_q[$];   // instructions decode is expected to accept, in order
  ctl_t        ctl_q[$];  // per-cycle expected control outputs
  bit          pend_valid = 1'b0;
  logic [31:0] pend_pc = 32'h0;
  logic [31:0] model_pc = 32'h0;
  bit          last_req = 1'b0;
  logic [31:0] last_addr = 32'h0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a + 32'h0000_0100;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: memory response, new inputs, and the model's view of this cycle
  task automatic step(input bit rn, input bit rd, input logic [31:0] rp, input bit rdy);
    ctl_t  c;
    inst_t head;
    bit    have_head;
    bit    from_pend;
    bit    pop;
    int    occ;
    @(posedge clk);
    #1;
    imem_rdata     = last_req ? word(last_addr) : $urandom;
    rst_n          = rn;
    redirect_valid = rd;
    redirect_pc    = rp;
    inst_ready     = rdy;
    c.rn = rn; c.addr = model_pc; c.req = 1'b0; c.valid = 1'b0;
    if (!rn) begin
      mq.delete();
      pend_valid = 1'b0;
      model_pc   = 32'h0;
    end else begin
      have_head = 1'b0;
      from_pend = 1'b0;
      if (mq.size() > 0) begin
        head = mq[0];
        have_head = 1'b1;
      end else if (BYPASS && pend_valid) begin
        head = '{pend_pc, word(pend_pc)};
        have_head = 1'b1;
        from_pend = 1'b1;
      end
      c.valid = !rd && have_head;
      pop     = c.valid && rdy;
      occ     = mq.size() + int'(pend_valid) - int'(pop);
      c.req   = !rd && (occ < DEPTH);
      if (pop) sb_q.push_back(head);
      if (rd) begin
        mq.delete();
        pend_valid = 1'b0;
        model_pc   = rp;
      end else begin
        if (pop && !from_pend) void'(mq.pop_front());
        if (pend_valid && !(pop && from_pend)) mq.push_back('{pend_pc, word(pend_pc)});
        pend_valid = c.req;
        pend_pc    = model_pc;
        if (c.req) model_pc = model_pc + 32'h1;
      end
    end
    ctl_q.push_back(c);
    @(negedge clk);
    last_req  = imem_req;
    last_addr = imem_addr;
  endtask

  // Monitor: per-cycle control checks and in-order comparison of every accepted instruction
  always @(negedge clk) begin : mon
    ctl_t  c;
    inst_t e;
    if (ctl_q.size() > 0) begin
      c = ctl_q.pop_front();
      check("imem_req", {31'b0, imem_req}, {31'b0, c.req});
      check("inst_valid", {31'b0, inst_valid}, {31'b0, c.valid});
      if (c.rn) check("imem_addr", imem_addr, c.addr);
    end
    if (inst_valid && inst_ready && !redirect_valid) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("inst_data", inst_data, e.data);
      end else begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc %h expected no accepted instruction at %0t", inst_pc, $time);
      end
    end
  end

  initial begin
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
    // stall until full, then drain in order
    step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
    // redirect with a partially filled queue, then one during streaming pop+push
    repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h40, 1'b1);
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h80, 1'b1);
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);
    // address wrap
    step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
    // reset with a full queue
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
    // random traffic
    repeat (600) step($urandom_range(0, 99) != 0, $urandom_range(0, 19) == 0,
                      $urandom, $urandom_range(0, 99) < 70);
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_prefetch_queue.md
IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): XLEN, 32, PC and instruction width; DEPTH, 4, queue entries (2..16); PC_STEP, 1, fetch-PC increment; RESET_PC, 0, PC after reset.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 imem_req  out  1  fetch request this cycle.
REQ-005 imem_addr  out  XLEN  fetch address, equal to fetch PC.
REQ-006 imem_rdata  in  XLEN  instruction word, valid exactly one cycle after imem_req.
REQ-007 redirect_valid  in  1  branch/jump taken; flush and refetch.
REQ-008 redirect_pc  in  XLEN  redirect target.
REQ-009 inst_valid  out  1  queue head holds a valid instruction.
REQ-010 inst_ready  in  1  decode accepts head (low = ID stall).
REQ-011 inst_data  out  XLEN  head instruction.
REQ-012 inst_pc  out  XLEN  PC of head instruction.

Function
REQ-013 The block SHALL hold fetch_pc, an in-flight flag, and a FIFO of DEPTH {pc, instruction} entries with an occupancy count of 0..DEPTH.
REQ-014 A pop SHALL occur in any cycle with inst_valid=1 and inst_ready=1 and redirect_valid=0.
REQ-015 imem_req SHALL be 1 iff rst_n=1, redirect_valid=0, and (count + inflight - pop) < DEPTH.
REQ-016 On imem_req=1: fetch_pc <= fetch_pc + PC_STEP (modulo 2^XLEN, wrap silently); inflight <= 1, else inflight <= 0.
REQ-017 When inflight=1 and redirect_valid=0, the block SHALL push {pc of that request, imem_rdata}; the issue rule guarantees no push into a full queue without a simultaneous pop.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order; pop on empty SHALL NOT occur because inst_valid=0.
REQ-019 Push-to-visibility latency SHALL be one cycle: request in cycle N, data captured end of N+1, inst_valid=1 in N+2.
REQ-020 redirect_valid=1 SHALL take priority over all other events: queue emptied (count <= 0), inflight <= 0, response arriving that cycle discarded, fetch_pc <= redirect_pc, imem_req=0 and inst_valid=0 in that cycle.
REQ-021 After redirect in cycle R, the first request SHALL issue at redirect_pc in R+1 and its instruction SHALL appear on inst_valid in R+3.
REQ-022 With inst_ready=0 indefinitely, the queue SHALL fill to exactly DEPTH entries, then imem_req SHALL stay 0; head outputs SHALL remain stable.
REQ-023 With inst_ready=1 continuously and no redirects, steady-state throughput SHALL be one instruction per cycle for every legal DEPTH.
REQ-024 inst_data and inst_pc SHALL be undefined-but-stable when inst_valid=0; no X shall propagate to inst_valid or imem_req.

Reset
REQ-025 While rst_n=0 at a rising edge: fetch_pc <= RESET_PC, count <= 0, inflight <= 0, FIFO pointers <= 0.
REQ-026 During and after a reset cycle: imem_req=0, inst_valid=0, imem_addr=RESET_PC; first request at RESET_PC in the first cycle with rst_n=1.
REQ-027 Reset asserted mid-operation SHALL discard queued entries and any response to a request issued before reset.

Configuration
REQ-028 Macro IF_PREFETCH_BYPASS_EN SHALL, when defined, present an arriving response (inflight=1, queue empty, no redirect) directly on inst_valid/inst_data/inst_pc in the same cycle; if popped that cycle it SHALL NOT be pushed.
REQ-029 With IF_PREFETCH_BYPASS_EN defined, push-to-visibility latency SHALL be zero (REQ-019 becomes N+1; REQ-021 becomes R+2); without it, REQ-019/REQ-021 apply unchanged.

Verification
REQ-030 Reset release, inst_ready=1, imem_rdata=addr+0x100 -> imem_addr 0,1,2,...; inst_valid from cycle 2 with inst_pc 0,1,2 and inst_data 0x100,0x101,0x102, one per cycle.
REQ-031 inst_ready=0 for 10 cycles -> exactly 4 requests (addr 0..3), count=4, imem_req=0; on inst_ready=1, heads 0,1,2,3 in order, fetch resumes at addr 4.
REQ-032 Redirect to 0x40 in cycle R while queue holds 3 entries -> inst_valid=0 in R, R+1, R+2; imem_addr=0x40 with imem_req=1 in R+1; inst_pc=0x40 in R+3.
REQ-033 Redirect asserted in the same cycle as a pop and a push -> neither takes effect; count=0 next cycle.
REQ-034 rst_n=0 for one cycle with queue full -> next cycle inst_valid=0, imem_addr=RESET_PC; stale response ignored.
REQ-035 DEPTH=2, fetch_pc=0xFFFFFFFF -> next imem_addr=0x00000000, throughput still one per cycle; repeat REQ-030 with IF_PREFETCH_BYPASS_EN defined -> first inst_valid in cycle 1.
